align_mem_resp: RTL and testbench
=================================

# align_mem_resp

Behavioural-synthesizable SRAM responder that sits on the memory side of the `align` word-packing core. It accepts `mem_read`/`mem_write` requests with per-bit write enables against a row-organised array of `NUMWRDS` packed words. It returns read data after a fixed `SRAM_DELAY` pipeline. Single-bit error injection lets the core's parity path (`serr`) be exercised in simulation and formal.

## Interface
Parameters:
- `WIDTH`, 32, data bits per logical word
- `PARITY`, 1, parity bits per logical word
- `NUMWRDS`, 4, logical words per physical row
- `BITWRDS`, 2, log2(NUMWRDS)
- `NUMSROW`, 256, physical rows
- `BITSROW`, 8, row address width
- `SRAM_DELAY`, 2, read latency in cycles (legal range 1..8)
- `MEMWDTH`, WIDTH+PARITY, derived; stored bits per word

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `mem_read` in 1: read request this cycle
- `mem_write` in 1: write request this cycle
- `mem_addr` in BITSROW: row address for read and/or write
- `mem_bw` in NUMWRDS*MEMWDTH: per-bit write enable
- `mem_din` in NUMWRDS*MEMWDTH: write data
- `mem_dout` out NUMWRDS*MEMWDTH: read data
- `rd_vld` out 1: `mem_dout` carries the response to a read
- `inj_en` in 1: flip one stored bit this cycle
- `inj_row` in BITSROW: injection row
- `inj_bit` in log2(NUMWRDS*MEMWDTH): injection bit index
- `uninit_rd` out 1: response is for a never-written row
- `oob_err` out 1: sticky flag, address ≥ NUMSROW seen

## Operation
Storage:
- Array of NUMSROW × NUMWRDS*MEMWDTH.
- Contents are not reset.
- A NUMSROW-bit `written` bitmap resets to 0. A row's bit is set on any in-range write with nonzero `mem_bw`.

Write:
- Row update is `row = (row & ~mem_bw) | (mem_din & mem_bw)`.
- Unmasked bits are untouched.

Read:
- The array row is captured in the request cycle and carried with a valid bit through a SRAM_DELAY-deep pipeline.
- If the row's `written` bit is 0 at capture, the captured data is forced to all-zero and `uninit_rd` rides the pipeline.

Simultaneous read+write to the same row in one cycle:
- Read returns the old contents (read-before-write).
- The write is applied.

Out-of-range address (`mem_addr` ≥ NUMSROW):
- Write is dropped.
- Read produces a response of all-zero with `rd_vld`=1.
- `oob_err` sets and stays set until reset.

Injection:
- `inj_en` XORs bit `inj_bit` of row `inj_row`. It does not touch the `written` bitmap.
- If it coincides with a write to the same row, the injection is applied after the masked write.
- An out-of-range `inj_row` or `inj_bit` is ignored, with no error flag.

## Timing
- Reset values: `mem_dout`=0, `rd_vld`=0, `uninit_rd`=0, `oob_err`=0, all pipeline valids 0, `written` all 0.
- Read latency: a request in cycle t yields `rd_vld`=1 and data in cycle t+SRAM_DELAY, for exactly one cycle.
- `mem_dout` holds its last value when `rd_vld`=0.
- Throughput: one read and one write per cycle, back-to-back, with no bubbles. SRAM_DELAY reads can be in flight.
- Write visibility:
  - A write in cycle t is visible to a read issued in t+1 or later.
  - A read in the same cycle t sees pre-write data.
- An injection in cycle t follows the same visibility rule as a write.
- Reset asserted mid-operation clears all in-flight reads immediately, so no response emerges after reset release. Array contents persist but read as uninit because the bitmap is cleared.
- `uninit_rd` is aligned with `rd_vld`.

## Structure
- Shared package `align_pkg` holds:
  - MEMWDTH derivation
  - a `row_t` typedef (NUMWRDS*MEMWDTH bits)
  - the masked-merge function `bw_merge(old, din, bw)`, which the `align` core's own model also uses
- One sub-module, `align_rd_pipe`: a parameterised SRAM_DELAY-deep valid+data+flag shift pipeline with async active-low reset.
- The top module contains the array, the bitmap, write/inject logic and the error flag.

## Test plan
- **Masked write then read.** Write row 5, `mem_din` all-ones, `mem_bw` low word only (bits [MEMWDTH-1:0]). Then read row 5. Required: `mem_dout` has the low word all-ones and the other words 0, `rd_vld` exactly at t+2, `uninit_rd`=0.
- **Read-before-write collision.** Row 3 holds 0xA pattern. In one cycle, read row 3 and write 0x5 pattern with full mask. Required: response shows 0xA. A read issued next cycle returns 0x5.
- **Back-to-back reads.** Read rows 0..7 on consecutive cycles after writing row i with value i. Required: `rd_vld` high for 8 consecutive cycles starting at t+SRAM_DELAY, data 0..7 in order. Repeat with SRAM_DELAY=1 and 4.
- **Uninit, reset and out-of-range.**
  - Read row 200 with no prior write. Required: data 0, `uninit_rd`=1.
  - Assert `rst` with 2 reads in flight. Required: no `rd_vld` after release.
  - Access row 300 with NUMSROW=256, BITSROW=9. Required: `oob_err` sets and stays set.
- **Error injection.**
  - Write row 7 with 0 and full mask, then `inj_en` with row 7, bit MEMWDTH. Read row 7. Required: only bit MEMWDTH of `mem_dout` is set.
  - Inject simultaneously with a full-mask write of all-ones to row 7. Required: read shows bit MEMWDTH cleared and all other bits set.

Source files
------------

// File: rtl/align_pkg.sv
// -----------------------------------------------------------------------------
// align_pkg
// Shared definitions for the align word-packing core and its SRAM responder.
//   - default geometry (logical word width, parity bits, words per row)
//   - memwdth():  stored bits per logical word
//   - row_t:      one physical row for the default geometry
//   - wide_row_t: container large enough for any supported row width
//   - bw_merge(): per-bit masked merge used for every row update
// -----------------------------------------------------------------------------
package align_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int PARITY_DEF  = 1;
  localparam int NUMWRDS_DEF = 4;

  // Stored bits per logical word: data plus its parity bits.
  function automatic int memwdth(input int width, input int parity);
    return width + parity;
  endfunction

  localparam int MEMWDTH_DEF = memwdth(WIDTH_DEF, PARITY_DEF);
  localparam int ROW_W_DEF   = NUMWRDS_DEF * MEMWDTH_DEF;

  typedef logic [ROW_W_DEF-1:0] row_t;

  // bw_merge works on a wide container so that responders built with a
  // non-default geometry share the very same merge; callers zero-extend
  // their rows into it and keep the low bits of the result.
  localparam int ROW_MAX_W = 1024;
  typedef logic [ROW_MAX_W-1:0] wide_row_t;

  // Bits enabled in bw take din, all other bits keep old_row.
  function automatic wide_row_t bw_merge(input wide_row_t old_row,
                                         input wide_row_t din,
                                         input wide_row_t bw);
    return (old_row & ~bw) | (din & bw);
  endfunction

endpackage

// File: rtl/align_rd_pipe.sv
// -----------------------------------------------------------------------------
// align_rd_pipe
// DEPTH-stage shift pipeline carrying a valid bit, a data word and a flag.
// A stage's data and flag only load when a valid entry moves into it, so the
// last stage keeps presenting the most recent response while idle.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset, clears valids and data
//   in_vld    : entry presented this cycle
//   in_data   : data captured with the entry
//   in_flag   : side flag captured with the entry
//   out_vld   : entry leaving the pipeline (DEPTH cycles after in_vld)
//   out_data  : data of the most recent entry to leave
//   out_flag  : side flag, qualified by out_vld
// -----------------------------------------------------------------------------
module align_rd_pipe #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 132
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_flag,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_data,
  output logic              out_flag
);

  logic [DEPTH-1:0]  vld;
  logic [DEPTH-1:0]  flag;
  logic [DATA_W-1:0] data [DEPTH];

  // NOTE: every register here is written with <= so all stages sample the
  // previous stage's old value on the same edge; blocking assignments would
  // collapse the pipeline into a single cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld  <= '0;
      flag <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data[i] <= '0;
      end
    end else begin
      vld[0] <= in_vld;
      if (in_vld) begin
        data[0] <= in_data;
        flag[0] <= in_flag;
      end
      for (int i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) begin
          data[i] <= data[i-1];
          flag[i] <= flag[i-1];
        end
      end
    end
  end

  assign out_vld  = vld[DEPTH-1];
  assign out_data = data[DEPTH-1];
  assign out_flag = vld[DEPTH-1] & flag[DEPTH-1];

endmodule

// File: rtl/align_mem_resp.sv
// -----------------------------------------------------------------------------
// align_mem_resp
// Behavioural SRAM responder for the memory side of the align core.
// Row-organised array of NUMWRDS packed words with per-bit write enables,
// fixed SRAM_DELAY read latency, single-bit error injection and tracking of
// never-written rows and out-of-range accesses.
//   clk        : rising-edge clock
//   rst        : asynchronous active-low reset
//   mem_read   : read request for row mem_addr this cycle
//   mem_write  : write request for row mem_addr this cycle
//   mem_addr   : row address shared by read and write
//   mem_bw     : per-bit write enable
//   mem_din    : write data
//   mem_dout   : read data, holds its last value while rd_vld is low
//   rd_vld     : mem_dout carries a read response
//   inj_en     : flip bit inj_bit of row inj_row this cycle
//   inj_row    : injection row
//   inj_bit    : injection bit index within the row
//   uninit_rd  : response belongs to a row never written since reset
//   oob_err    : sticky, an access to a row >= NUMSROW was seen
// -----------------------------------------------------------------------------
module align_mem_resp
  import align_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int PARITY     = 1,
  parameter int NUMWRDS    = 4,
  parameter int BITWRDS    = 2,
  parameter int NUMSROW    = 256,
  parameter int BITSROW    = 8,
  parameter int SRAM_DELAY = 2,
  parameter int MEMWDTH    = memwdth(WIDTH, PARITY)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               mem_read,
  input  logic                               mem_write,
  input  logic [BITSROW-1:0]                 mem_addr,
  input  logic [NUMWRDS*MEMWDTH-1:0]         mem_bw,
  input  logic [NUMWRDS*MEMWDTH-1:0]         mem_din,
  output logic [NUMWRDS*MEMWDTH-1:0]         mem_dout,
  output logic                               rd_vld,
  input  logic                               inj_en,
  input  logic [BITSROW-1:0]                 inj_row,
  input  logic [BITWRDS+$clog2(MEMWDTH)-1:0] inj_bit,
  output logic                               uninit_rd,
  output logic                               oob_err
);

  localparam int ROW_W = NUMWRDS * MEMWDTH;
  localparam int IDX_W = (NUMSROW > 1) ? $clog2(NUMSROW) : 1;

  typedef logic [ROW_W-1:0] row_w_t;

  function automatic row_w_t merge_row(input row_w_t old_row,
                                       input row_w_t din,
                                       input row_w_t bw);
    wide_row_t merged;
    merged = bw_merge(wide_row_t'(old_row), wide_row_t'(din), wide_row_t'(bw));
    return merged[ROW_W-1:0];
  endfunction

  row_w_t             mem [NUMSROW];
  logic [NUMSROW-1:0] written;

  logic [IDX_W-1:0] addr_idx;
  logic [IDX_W-1:0] inj_idx;
  logic             addr_ok;
  logic             wr_ok;
  logic             inj_ok;

  row_w_t old_row;
  row_w_t wr_row;
  row_w_t inj_base;
  row_w_t inj_mask;
  row_w_t rd_row;
  logic   rd_uninit;

  assign addr_idx = mem_addr[IDX_W-1:0];
  assign inj_idx  = inj_row[IDX_W-1:0];
  assign addr_ok  = 32'(mem_addr) < 32'(NUMSROW);
  assign wr_ok    = mem_write && addr_ok;
  assign inj_ok   = inj_en && (32'(inj_row) < 32'(NUMSROW))
                           && (32'(inj_bit) < 32'(ROW_W));
  assign inj_mask = row_w_t'(1) << inj_bit;

  // A never-written row is all-zero as far as the outside world can tell, so
  // a partial write merges into zero rather than into stale array contents.
  // An injection coinciding with a write to the same row lands on top of the
  // freshly merged value.
  // NOTE: every signal driven here gets a value on every path, starting with
  // defaults, so no latch can be inferred.
  always_comb begin
    old_row  = '0;
    inj_base = '0;
    if (written[addr_idx]) begin
      old_row = mem[addr_idx];
    end
    wr_row = merge_row(old_row, mem_din, mem_bw);
    if (wr_ok && (inj_idx == addr_idx)) begin
      inj_base = wr_row;
    end else begin
      inj_base = mem[inj_idx];
    end
  end

  // NOTE: the array itself has no reset; clearing every row would turn the
  // memory into flops. Reads of rows not written since reset are masked to
  // zero through the written bitmap instead.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[addr_idx] <= wr_row;
    end
    if (inj_ok) begin
      mem[inj_idx] <= inj_base ^ inj_mask;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      written <= '0;
      oob_err <= 1'b0;
    end else begin
      if (wr_ok && (mem_bw != '0)) begin
        written[addr_idx] <= 1'b1;
      end
      if ((mem_read || mem_write) && !addr_ok) begin
        oob_err <= 1'b1;
      end
    end
  end

  // The array is read combinationally in the request cycle, before any
  // same-cycle write lands, which gives read-before-write on a collision.
  assign rd_uninit = addr_ok && !written[addr_idx];
  assign rd_row    = (addr_ok && written[addr_idx]) ? mem[addr_idx] : '0;

  align_rd_pipe #(
    .DEPTH  (SRAM_DELAY),
    .DATA_W (ROW_W)
  ) u_rd_pipe (
    .clk      (clk),
    .rst_n    (rst),
    .in_vld   (mem_read),
    .in_data  (rd_row),
    .in_flag  (rd_uninit),
    .out_vld  (rd_vld),
    .out_data (mem_dout),
    .out_flag (uninit_rd)
  );

endmodule

// File: tb/tb_align_mem_resp.sv
// -----------------------------------------------------------------------------
// tb_align_mem_resp
// Three responders (SRAM_DELAY 2, 1 and 4; 256 rows behind a 9-bit address)
// share one stimulus stream. A behavioural memory model produces the response
// of every request cycle; a single compare process checks each instance's
// outputs against that response, delayed by the instance's latency, on every
// falling edge. Directed sequences add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_align_mem_resp;

  localparam int MEMWDTH = 33;
  localparam int ROW_W   = 4 * MEMWDTH;
  localparam int NROW    = 256;
  localparam int NINST   = 3;
  localparam int DLY [NINST] = '{2, 1, 4};

  typedef logic [ROW_W-1:0] row_w_t;

  typedef struct packed {
    logic   vld;
    logic   chk_un;
    logic   un;
    row_w_t data;
  } resp_t;

  localparam row_w_t ALL1   = {ROW_W{1'b1}};
  localparam row_w_t LOW_W  = 132'h1_FFFF_FFFF;
  localparam row_w_t BIT33  = 132'h2_0000_0000;
  localparam row_w_t PAT_A  = {33{4'hA}};
  localparam row_w_t PAT_5  = {33{4'h5}};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mem_read = 1'b0;
  logic       mem_write = 1'b0;
  logic [8:0] mem_addr = '0;
  row_w_t     mem_bw = '0;
  row_w_t     mem_din = '0;
  logic       inj_en = 1'b0;
  logic [8:0] inj_row = '0;
  logic [7:0] inj_bit = '0;

  row_w_t dout [NINST];
  logic   vld  [NINST];
  logic   unin [NINST];
  logic   oob  [NINST];

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NINST; g++) begin : g_dut
    align_mem_resp #(
      .WIDTH      (32),
      .PARITY     (1),
      .NUMWRDS    (4),
      .BITWRDS    (2),
      .NUMSROW    (NROW),
      .BITSROW    (9),
      .SRAM_DELAY (DLY[g])
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_addr  (mem_addr),
      .mem_bw    (mem_bw),
      .mem_din   (mem_din),
      .mem_dout  (dout[g]),
      .rd_vld    (vld[g]),
      .inj_en    (inj_en),
      .inj_row   (inj_row),
      .inj_bit   (inj_bit),
      .uninit_rd (unin[g]),
      .oob_err   (oob[g])
    );
  end

  task automatic check(input string name, input row_w_t act, input row_w_t exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: the memory as the outside world sees it. Rows that have
  // not been written since reset hold zero; the response of each request cycle
  // is recorded in a small history ring indexed by request cycle number.
  // ---------------------------------------------------------------------------
  row_w_t m_mem [0:511];
  logic   m_wr  [0:511];
  logic   m_oob;
  resp_t  hist  [16];
  resp_t  r_now;
  int     cyc = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 512; r++) begin
        m_mem[r] = '0;
        m_wr[r]  = 1'b0;
      end
      for (int k = 0; k < 16; k++) hist[k] = '0;
      m_oob = 1'b0;
    end else begin
      r_now = '0;
      if (mem_read) begin
        r_now.vld = 1'b1;
        if (int'(mem_addr) < NROW) begin
          r_now.chk_un = 1'b1;
          r_now.un     = !m_wr[mem_addr];
          r_now.data   = m_mem[mem_addr];
        end
      end
      if (mem_write && int'(mem_addr) < NROW) begin
        m_mem[mem_addr] = (m_mem[mem_addr] & ~mem_bw) | (mem_din & mem_bw);
        if (mem_bw != '0) m_wr[mem_addr] = 1'b1;
      end
      if ((mem_read || mem_write) && int'(mem_addr) >= NROW) m_oob = 1'b1;
      // A flip in a row that still reads as zero has no visible effect.
      if (inj_en && int'(inj_row) < NROW && int'(inj_bit) < ROW_W && m_wr[inj_row])
        m_mem[inj_row][inj_bit] = ~m_mem[inj_row][inj_bit];
      hist[cyc % 16] = r_now;
      cyc++;
    end
  end

  // ---------------------------------------------------------------------------
  // Compare process: every falling edge, every instance.
  // ---------------------------------------------------------------------------
  row_w_t exp_last [NINST];

  always @(negedge clk) begin
    for (int i = 0; i < NINST; i++) begin
      resp_t e;
      e = '0;
      if (!rst) begin
        exp_last[i] = '0;
        check($sformatf("rst_vld[%0d]", i), row_w_t'(vld[i]), '0);
        check($sformatf("rst_dout[%0d]", i), dout[i], '0);
        check($sformatf("rst_oob[%0d]", i), row_w_t'(oob[i]), '0);
      end else begin
        if (cyc >= DLY[i]) e = hist[(cyc - DLY[i]) % 16];
        check($sformatf("rd_vld[%0d]", i), row_w_t'(vld[i]), row_w_t'(e.vld));
        if (e.vld) exp_last[i] = e.data;
        check($sformatf("mem_dout[%0d]", i), dout[i], exp_last[i]);
        if (!e.vld)
          check($sformatf("uninit_idle[%0d]", i), row_w_t'(unin[i]), '0);
        else if (e.chk_un)
          check($sformatf("uninit_rd[%0d]", i), row_w_t'(unin[i]), row_w_t'(e.un));
        check($sformatf("oob_err[%0d]", i), row_w_t'(oob[i]), row_w_t'(m_oob));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers. Inputs change 2 time units after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_bw    = '0;
    mem_din   = '0;
    inj_en    = 1'b0;
  endtask

  task automatic wr(input logic [8:0] a, input row_w_t bw, input row_w_t d);
    idle();
    mem_write = 1'b1;
    mem_addr  = a;
    mem_bw    = bw;
    mem_din   = d;
    tick();
    idle();
  endtask

  task automatic rd(input logic [8:0] a);
    idle();
    mem_read = 1'b1;
    mem_addr = a;
    tick();
    idle();
  endtask

  // After rd() returns, the second falling edge is where the SRAM_DELAY=2
  // instance presents the response; the first one must still be idle.
  task automatic await_d2(input string name);
    @(negedge clk);
    check({name, "_early"}, row_w_t'(vld[0]), '0);
    @(negedge clk);
    check({name, "_vld"}, row_w_t'(vld[0]), row_w_t'(1));
  endtask

  function automatic row_w_t rand_row();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[ROW_W-1:0];
  endfunction

  task automatic back_to_back();
    int seen  [NINST];
    int first [NINST];
    int last  [NINST];
    for (int i = 0; i < 8; i++) wr(9'(i), ALL1, row_w_t'(i));
    for (int k = 0; k < NINST; k++) begin
      seen[k]  = 0;
      first[k] = -1;
      last[k]  = -1;
    end
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          mem_read = 1'b1;
          mem_addr = 9'(i);
          tick();
        end
        idle();
      end
      begin
        for (int n = 0; n < 16; n++) begin
          @(negedge clk);
          for (int k = 0; k < NINST; k++) begin
            if (vld[k]) begin
              check($sformatf("b2b_data[%0d]", k), dout[k], row_w_t'(seen[k]));
              if (first[k] < 0) first[k] = n;
              last[k] = n;
              seen[k]++;
            end
          end
        end
      end
    join
    for (int k = 0; k < NINST; k++) begin
      check($sformatf("b2b_count[%0d]", k), row_w_t'(seen[k]), row_w_t'(8));
      check($sformatf("b2b_span[%0d]", k), row_w_t'(last[k] - first[k]), row_w_t'(7));
      check($sformatf("b2b_start[%0d]", k), row_w_t'(first[k]), row_w_t'(DLY[k]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "simulation did not complete");
  end

  initial begin
    int vld_after;
    idle();
    repeat (3) tick();
    @(negedge clk);
    check("reset_dout", dout[0], '0);
    check("reset_vld", row_w_t'(vld[0]), '0);
    check("reset_oob", row_w_t'(oob[0]), '0);
    tick();
    rst = 1'b1;
    tick();

    // Masked write of the low word, then read it back.
    wr(9'd5, LOW_W, ALL1);
    rd(9'd5);
    await_d2("masked");
    check("masked_data", dout[0], LOW_W);
    check("masked_uninit", row_w_t'(unin[0]), '0);

    // Never-written row reads as zero and flagged.
    rd(9'd200);
    await_d2("uninit");
    check("uninit_data", dout[0], '0);
    check("uninit_flag", row_w_t'(unin[0]), row_w_t'(1));

    // Read-before-write collision, then a read of the new contents.
    wr(9'd3, ALL1, PAT_A);
    idle();
    mem_read  = 1'b1;
    mem_write = 1'b1;
    mem_addr  = 9'd3;
    mem_bw    = ALL1;
    mem_din   = PAT_5;
    tick();
    idle();
    mem_read = 1'b1;
    mem_addr = 9'd3;
    tick();
    idle();
    @(negedge clk);
    check("collide_old", dout[0], PAT_A);
    @(negedge clk);
    check("collide_new", dout[0], PAT_5);

    back_to_back();

    // Injection into a zeroed row, then injection on top of a full write.
    wr(9'd7, ALL1, '0);
    idle();
    inj_en  = 1'b1;
    inj_row = 9'd7;
    inj_bit = 8'd33;
    tick();
    idle();
    rd(9'd7);
    await_d2("inject");
    check("inject_data", dout[0], BIT33);
    idle();
    mem_write = 1'b1;
    mem_addr  = 9'd7;
    mem_bw    = ALL1;
    mem_din   = ALL1;
    inj_en    = 1'b1;
    inj_row   = 9'd7;
    inj_bit   = 8'd33;
    tick();
    idle();
    rd(9'd7);
    await_d2("inject_wr");
    check("inject_wr_data", dout[0], ~BIT33);

    // Out-of-range accesses: zero response, sticky flag, write dropped.
    check("oob_before", row_w_t'(oob[0]), '0);
    rd(9'd300);
    await_d2("oob");
    check("oob_data", dout[0], '0);
    check("oob_flag", row_w_t'(oob[0]), row_w_t'(1));
    wr(9'd300, ALL1, ALL1);
    rd(9'd44);
    await_d2("oob_alias");
    check("oob_alias_data", dout[0], '0);
    check("oob_alias_uninit", row_w_t'(unin[0]), row_w_t'(1));
    check("oob_sticky", row_w_t'(oob[0]), row_w_t'(1));

    // Reset with reads in flight: nothing may emerge afterwards.
    rd(9'd5);
    rd(9'd3);
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    vld_after = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      for (int k = 0; k < NINST; k++) if (vld[k]) vld_after++;
    end
    check("post_reset_vld", row_w_t'(vld_after), '0);
    check("post_reset_oob", row_w_t'(oob[0]), '0);
    rd(9'd5);
    await_d2("post_reset");
    check("post_reset_data", dout[0], '0);
    check("post_reset_uninit", row_w_t'(unin[0]), row_w_t'(1));

    // Randomised traffic concentrated on a few rows to provoke collisions.
    for (int n = 0; n < 1500; n++) begin
      idle();
      mem_read  = 1'($urandom_range(0, 1));
      mem_write = 1'($urandom_range(0, 1));
      mem_addr  = ($urandom_range(0, 7) == 0) ? 9'($urandom_range(256, 511))
                                              : 9'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       mem_bw = '0;
        1:       mem_bw = ALL1;
        2:       mem_bw = rand_row();
        default: mem_bw = row_w_t'({MEMWDTH{1'b1}}) << (MEMWDTH * $urandom_range(0, 3));
      endcase
      mem_din = rand_row();
      inj_en  = ($urandom_range(0, 4) == 0);
      inj_row = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(0, 511))
                                            : 9'($urandom_range(0, 15));
      inj_bit = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(132, 255))
                                            : 8'($urandom_range(0, 131));
      if (n == 700) begin
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
      end
      tick();
    end
    idle();
    repeat (8) tick();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
